// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI video path: raster constants, pixel type and feeder states.
package hdmi_pkg;

  // Active raster, shared with hdmi_core.
  localparam int unsigned H_ACTIVE = 960;
  localparam int unsigned V_ACTIVE = 600;

  // Blanking and sync timing, shared with hdmi_core.
  localparam int unsigned H_FRONT  = 40;
  localparam int unsigned H_SYNC   = 128;
  localparam int unsigned H_BACK   = 88;
  localparam int unsigned V_FRONT  = 1;
  localparam int unsigned V_SYNC   = 4;
  localparam int unsigned V_BACK   = 23;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    RESYNC,
    ARM,
    RUN
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered storage and a flush that still accepts a push.
module sync_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [AW-1:0]    waddr;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  // A flush empties the FIFO, but a same-cycle push lands in slot 0.
  assign wr_en = push_i && (flush_i || !full_o);
  assign rd_en = pop_i && !empty_o && !flush_i;
  assign waddr = flush_i ? '0 : wptr_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = AW'(wr_en);
      level_d = LW'(wr_en);
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      if (wr_en && !rd_en) begin
        level_d = level_q + 1'b1;
      end else if (!wr_en && rd_en) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents need no reset since reads are qualified by empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[waddr] <= wdata_i;
  end

endmodule

// File: rtl/hdmi_pixel_feeder.sv
// Buffers the source pixel stream and feeds hdmi_core one pixel per rgb_ready, frame-aligned.
module hdmi_pixel_feeder
  import hdmi_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned HWIDTH   = H_ACTIVE,
  parameter int unsigned VHEIGHT  = V_ACTIVE,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [23:0]            s_data,
  input  logic                   s_sof,
  input  logic                   rgb_ready,
  input  logic                   vblank,
  output logic [7:0]             red,
  output logic [7:0]             grn,
  output logic [7:0]             blu,
  output logic                   locked,
  output logic                   underflow,
  output logic                   sync_err,
  input  logic                   clr_status,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned NPIX = HWIDTH * VHEIGHT;
  localparam int unsigned PW   = $clog2(NPIX);
  localparam logic [PW-1:0] PCNT_MAX = PW'(NPIX - 1);

  feeder_state_e state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          vblank_q;
  logic          underflow_q, sync_err_q;
  logic          set_uf, set_se;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [24:0]   fifo_head;
  rgb_t          head_rgb, out_rgb;
  logic          head_sof;

  sync_fifo #(
    .WIDTH (25),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i ({s_sof, s_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign head_sof = fifo_head[24];
  assign head_rgb = rgb_t'(fifo_head[23:0]);

  // Next-state, FIFO control and flag-set decode.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    set_uf     = 1'b0;
    set_se     = 1'b0;
    s_ready    = !fifo_full;
    unique case (state_q)
      RESYNC: begin
        // Everything is accepted; only a frame start survives the flush.
        s_ready    = 1'b1;
        fifo_flush = 1'b1;
        pcnt_d     = '0;
        if (s_valid && s_sof) begin
          fifo_push = 1'b1;
          state_d   = ARM;
        end
      end
      ARM: begin
        fifo_push = s_valid && !fifo_full;
        if (vblank_q && !vblank) state_d = RUN;
      end
      RUN: begin
        fifo_push = s_valid && !fifo_full;
        if (rgb_ready) begin
          pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + 1'b1;
          if (fifo_empty) begin
            set_uf = 1'b1;
          end else if (head_sof != (pcnt_q == '0)) begin
            set_se  = 1'b1;
            state_d = RESYNC;
          end else begin
            fifo_pop = 1'b1;
          end
        end
      end
      default: state_d = RESYNC;
    endcase
  end

  // FSM, pixel counter, vblank history and sticky status flags; set wins over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESYNC;
      pcnt_q      <= '0;
      vblank_q    <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      vblank_q    <= vblank;
      underflow_q <= set_uf | (underflow_q & ~clr_status);
      sync_err_q  <= set_se | (sync_err_q & ~clr_status);
    end
  end

  // Output pixel mux from the registered FIFO head.
  always_comb begin
    out_rgb = rgb_t'(FILL_RGB);
    if (state_q == RUN && !fifo_empty) out_rgb = head_rgb;
  end

  assign red       = out_rgb.r;
  assign grn       = out_rgb.g;
  assign blu       = out_rgb.b;
  assign locked    = (state_q == RUN);
  assign underflow = underflow_q;
  assign sync_err  = sync_err_q;

endmodule

// File: doc/hdmi_pixel_feeder.md
# hdmi_pixel_feeder

Upstream neighbour of `hdmi_core`, running in the `pixclk` domain. It buffers a valid/ready RGB pixel stream from the DMA/pattern source in a small show-ahead FIFO. It presents one pixel per `rgb_ready` cycle on `red/grn/blu` and keeps the stream frame-aligned to the core's raster using a start-of-frame marker and `vblank`. On underflow or misalignment it substitutes a fill colour and resynchronises at the next frame.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, ≥4.
- `HWIDTH`, 960: active pixels per line; must match `hdmi_core`.
- `VHEIGHT`, 600: active lines per frame; must match `hdmi_core`.
- `FILL_RGB`, 24'h000000: colour driven when no valid pixel is available, as {r,g,b}.

- `clk` in 1: pixel clock (`pixclk`).
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted when `s_valid && s_ready`.
- `s_data` in 24: pixel {r[7:0], g[7:0], b[7:0]}.
- `s_sof` in 1: marks the first pixel of a frame.
- `rgb_ready` in 1: from `hdmi_core`; the pixel is consumed at this edge.
- `vblank` in 1: from `hdmi_core`.
- `red`, `grn`, `blu` out 8 each: pixel to `hdmi_core`.
- `locked` out 1: high in state RUN.
- `underflow` out 1: sticky; set on a consume from an empty FIFO.
- `sync_err` out 1: sticky; set on a marker mismatch.
- `clr_status` in 1: synchronous clear of both sticky flags. Set takes priority over clear in the same cycle.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO entries are 25 bits: {sof, rgb}.
- Push condition: `s_valid && s_ready && !full`. Pop occurs only in RUN on `rgb_ready && !empty`.
- `s_ready` is `!full` in ARM and RUN, and 1 in RESYNC. There is no pass-through; a push into an empty FIFO appears at the head the next cycle.
- Pixel counter `pcnt`: 20 bits for the default parameters (width `$clog2(HWIDTH*VHEIGHT)`).
  - Increments on every RUN cycle with `rgb_ready`, whether or not a pixel was popped.
  - Wraps to 0 after `HWIDTH*VHEIGHT-1`.
- State machine (reset state is RESYNC):
  - **RESYNC**: flush the FIFO and hold `pcnt` at 0. Every beat without `s_sof` is accepted and dropped. A beat with `s_sof` is pushed, and the next state is ARM.
  - **ARM**: push normally, never pop. Detect a falling edge of `vblank` using a registered copy of `vblank`. On that edge, go to RUN.
  - **RUN**: on `rgb_ready`:
    - If the FIFO is empty: set `underflow`, output `FILL_RGB`, and stay in RUN.
    - Otherwise, if the head's `sof != (pcnt == 0)`: set `sync_err`, do not pop, go to RESYNC.
    - Otherwise: pop.
- Output mux: `{red,grn,blu}` is the FIFO head's rgb when in RUN and the FIFO is non-empty; otherwise `FILL_RGB`. The mux is combinational from the registered FIFO head.
- An `s_sof` beat arriving while in ARM or RUN is pushed normally. It is checked only when it reaches the head.

## Timing
- Reset values:
  - `s_ready` = 1 (RESYNC).
  - `locked` = 0, `underflow` = 0, `sync_err` = 0, `level` = 0.
  - `{red,grn,blu}` = `FILL_RGB`.
  - `pcnt` = 0, `vblank` history register = 0.
- Asserting `reset_n` mid-frame forces RESYNC and an empty FIFO immediately.
- `{red,grn,blu}` are valid in the same cycle `rgb_ready` is high. `hdmi_core`'s encoder samples them at that edge.
- Full FIFO with push and pop in the same cycle: `s_ready` = 0, so only the pop occurs.
- Empty FIFO with push and `rgb_ready` in the same cycle: underflow is flagged, the push lands, and `level` becomes 1.
- RUN→RESYNC takes effect at the next edge. `locked` falls in the following cycle, and the FIFO is empty one cycle later.
- ARM→RUN happens at the edge after `vblank` falls. This is well before line 0 is active.

## Structure
- Shared package `hdmi_pkg` holds:
  - the `HWIDTH`/`VHEIGHT`/sync timing constants, also shared with `hdmi_core`;
  - the `rgb_t` packed struct {r,g,b};
  - the feeder state enum `{RESYNC, ARM, RUN}`.
- One sub-module: `sync_fifo` (parameters WIDTH and DEPTH; show-ahead, registered storage, `flush` input, `level` output).
- The FSM, `pcnt` and the status flags live in `hdmi_pixel_feeder`.

## Test plan
- **Lock:** after reset, send 3 beats without sof, then a sof frame of 576000 pixels with incrementing values. Required: the first 3 beats are dropped, `locked` rises after `vblank` falls, and the first `rgb_ready` pixel equals the sof pixel. Run two full frames and compare every pixel.
- **Underflow:** stall `s_valid` for 10 `rgb_ready` cycles mid-line. Required: 10 pixels of `FILL_RGB`, `underflow` = 1, `locked` stays 1, and `pcnt` advanced by 10.
- **Misalignment:** inject `s_sof` at pixel 1000 of a frame. Required: `sync_err` = 1 when that pixel reaches the head, `locked` = 0, and the block relocks on the next sof and `vblank` fall.
- **Backpressure:** hold `rgb_ready` low with `DEPTH`+4 beats offered. Required: `level` = `DEPTH`, `s_ready` = 0, and no beat is lost or duplicated.
- **Status and reset:** pulse `clr_status` together with a new underflow and check the flag stays 1. Then assert `reset_n` mid-frame. Required: all outputs return to their reset values immediately.
